// File: rtl/sysdefs.svh
// System-wide width definitions shared by the solver blocks.
`ifndef SYSDEFS_SVH
`define SYSDEFS_SVH
`define MAX_VARS_BITS 8
`define MAX_CLAUSES_BITS 10
`endif

// File: rtl/bcp_clause_eval.sv
// Purpose: BCP clause evaluator; fetches queued clauses, reads var state, emits unit implications or a sticky conflict.
// Latency: bcp_en in cycle N gives push_imply/conflict in cycle N+LITS+4; LITS+4 cycles per clause, no bubble between clauses.
// Backpressure: imply_full holds the engine in OUTCOME; intake beyond FIFO_DEPTH is dropped and flagged on overflow.
// Optional feature: define BCP_EARLY_EXIT_EN to end a clause as soon as a satisfied literal is seen.
`include "sysdefs.svh"

module bcp_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr_en,
  input  logic [W-1:0] wr_dat,
  input  logic         rd_en,
  output logic [W-1:0] rd_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_wr;
  logic         do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write on full is still taken.
  assign do_wr  = wr_en && (!full || do_rd);
  assign rd_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush discards all contents and any same-cycle write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, written only when the write is accepted.
  always_ff @(posedge clock) begin
    if (do_wr && !flush) mem[wr_ptr[AW-1:0]] <= wr_dat;
  end
endmodule

module bcp_clause_eval #(
  parameter int LITS       = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   reset_bcp,
  input  logic                                   bcp_en,
  input  logic [`MAX_CLAUSES_BITS-1:0]           bcp_clause_idx,
  output logic                                   clause_rd_en,
  output logic [`MAX_CLAUSES_BITS-1:0]           clause_rd_idx,
  input  logic [LITS*(`MAX_VARS_BITS+2)-1:0]     clause_lits,
  output logic                                   vs_rd_en,
  output logic [`MAX_VARS_BITS-1:0]              vs_rd_var,
  input  logic                                   vs_val,
  input  logic                                   vs_unassign,
  input  logic                                   imply_full,
  output logic                                   push_imply,
  output logic [`MAX_VARS_BITS-1:0]              var_in_imply,
  output logic                                   val_in_imply,
  output logic                                   type_in_imply,
  output logic                                   bcp_busy,
  output logic                                   conflict,
  output logic                                   overflow
);
  localparam int VB = `MAX_VARS_BITS;
  localparam int CB = `MAX_CLAUSES_BITS;
  localparam int LW = VB + 2;
  localparam int KW = $clog2(LITS + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] SCAN    = 3'd3;
  localparam logic [2:0] RESOLVE = 3'd4;
  localparam logic [2:0] OUTCOME = 3'd5;

  logic [2:0]                state_q, state_d;
  logic [KW-1:0]             k_q;
  logic [LITS-1:0][LW-1:0]   lits_q;
  logic [1:0]                ucnt_q, ucnt_nx;
  logic                      sat_q, sat_nx;
  logic [VB:0]               cand_q, cand_nx;   // {neg, var} of last unassigned literal
  logic                      conflict_q, overflow_q;

  logic                      fifo_empty, fifo_full;
  logic [CB-1:0]             fifo_head;
  logic                      intake, pop, flush;
  logic                      eval_en, lit_sat, lit_unas, early_exit;
  logic [KW-1:0]             eval_idx;
  logic [LW-1:0]             eval_lit;
  logic [VB-1:0]             scan_var;
  logic                      res_empty, res_unit;

  assign intake = bcp_en && !conflict_q && !reset_bcp;
  assign pop    = (state_q == FETCH) && !reset_bcp;
  assign flush  = reset_bcp || ((state_q == OUTCOME) && !sat_q && (ucnt_q == 2'd0));

  bcp_fifo #(.W(CB), .DEPTH(FIFO_DEPTH)) u_idx_fifo (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .wr_en  (intake),
    .wr_dat (bcp_clause_idx),
    .rd_en  (pop),
    .rd_dat (fifo_head),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Var-state data returns one cycle after the read, so SCAN k evaluates literal k-1.
  assign eval_en  = ((state_q == SCAN) && (k_q != '0)) || (state_q == RESOLVE);
  assign eval_idx = (state_q == RESOLVE) ? KW'(LITS - 1) : (k_q - KW'(1));

  // Select the literal being evaluated and the variable being read this cycle.
  always_comb begin
    eval_lit = '0;
    scan_var = '0;
    for (int i = 0; i < LITS; i++) begin
      if (eval_idx == KW'(i)) eval_lit = lits_q[i];
      if (k_q == KW'(i))      scan_var = lits_q[i][VB-1:0];
    end
  end

  assign lit_unas = eval_en && eval_lit[LW-1] && vs_unassign;
  assign lit_sat  = eval_en && eval_lit[LW-1] && !vs_unassign && (vs_val ^ eval_lit[LW-2]);

`ifdef BCP_EARLY_EXIT_EN
  assign early_exit = lit_sat;
`else
  assign early_exit = 1'b0;
`endif

  // Accumulate the clause summary including the literal evaluated this cycle.
  always_comb begin
    sat_nx  = sat_q | lit_sat;
    ucnt_nx = ucnt_q;
    cand_nx = cand_q;
    if (lit_unas) begin
      ucnt_nx = (ucnt_q == 2'd2) ? 2'd2 : ucnt_q + 2'd1;
      cand_nx = eval_lit[VB:0];
    end
  end

  assign res_empty = !sat_q && (ucnt_q == 2'd0);
  assign res_unit  = !sat_q && (ucnt_q == 2'd1);

  // Next-state: idle waits for work, a clause walks FETCH..OUTCOME, then chains to the next.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!conflict_q && (!fifo_empty || intake)) state_d = FETCH;
      FETCH:   state_d = LOAD;
      LOAD:    state_d = SCAN;
      SCAN: begin
        if (early_exit)                  state_d = fifo_empty ? IDLE : FETCH;
        else if (k_q == KW'(LITS - 1))   state_d = RESOLVE;
      end
      RESOLVE: state_d = early_exit ? (fifo_empty ? IDLE : FETCH) : OUTCOME;
      OUTCOME: begin
        if (res_empty)                   state_d = IDLE;
        else if (res_unit && imply_full) state_d = OUTCOME;
        else                             state_d = fifo_empty ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and datapath registers; reset_bcp overrides everything else in its cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      k_q        <= '0;
      lits_q     <= '0;
      ucnt_q     <= 2'd0;
      sat_q      <= 1'b0;
      cand_q     <= '0;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (reset_bcp) begin
      state_q    <= IDLE;
      conflict_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (intake && fifo_full && !pop) overflow_q <= 1'b1;
      // Conflict is decided as RESOLVE closes so it is visible in the OUTCOME cycle.
      if ((state_q == RESOLVE) && !sat_nx && (ucnt_nx == 2'd0)) conflict_q <= 1'b1;
      case (state_q)
        LOAD: begin
          lits_q <= clause_lits;
          k_q    <= '0;
          ucnt_q <= 2'd0;
          sat_q  <= 1'b0;
          cand_q <= '0;
        end
        SCAN, RESOLVE: begin
          k_q    <= k_q + KW'(1);
          ucnt_q <= ucnt_nx;
          sat_q  <= sat_nx;
          cand_q <= cand_nx;
        end
        default: ;
      endcase
    end
  end

  assign clause_rd_en  = (state_q == FETCH);
  assign clause_rd_idx = clause_rd_en ? fifo_head : '0;
  assign vs_rd_en      = (state_q == SCAN) && !early_exit;
  assign vs_rd_var     = vs_rd_en ? scan_var : '0;
  assign push_imply    = (state_q == OUTCOME) && res_unit && !imply_full && !reset_bcp;
  assign var_in_imply  = push_imply ? cand_q[VB-1:0] : '0;
  assign val_in_imply  = push_imply && !cand_q[VB];
  assign type_in_imply = push_imply;
  assign bcp_busy      = bcp_en || !fifo_empty || (state_q != IDLE);
  assign conflict      = conflict_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_bcp_clause_eval.sv
// Directed bench for bcp_clause_eval: unit, conflict, empty clause, stream, backpressure, overflow, async reset, early exit.
// Clause DB and var-state table are modelled as one-cycle-latency memories.
// Build with BCP_EARLY_EXIT_EN defined to check the early-exit timings.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 8
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 10
`endif

module tb_bcp_clause_eval;
  localparam int LITS = 3;
  localparam int VB   = `MAX_VARS_BITS;
  localparam int CB   = `MAX_CLAUSES_BITS;
  localparam int LW   = VB + 2;

  logic                 clock;
  logic                 reset;
  logic                 reset_bcp;
  logic                 bcp_en;
  logic [CB-1:0]        bcp_clause_idx;
  logic                 clause_rd_en;
  logic [CB-1:0]        clause_rd_idx;
  logic [LITS*LW-1:0]   clause_lits;
  logic                 vs_rd_en;
  logic [VB-1:0]        vs_rd_var;
  logic                 vs_val;
  logic                 vs_unassign;
  logic                 imply_full;
  logic                 push_imply;
  logic [VB-1:0]        var_in_imply;
  logic                 val_in_imply;
  logic                 type_in_imply;
  logic                 bcp_busy;
  logic                 conflict;
  logic                 overflow;

  bcp_clause_eval #(.LITS(LITS), .FIFO_DEPTH(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .reset_bcp      (reset_bcp),
    .bcp_en         (bcp_en),
    .bcp_clause_idx (bcp_clause_idx),
    .clause_rd_en   (clause_rd_en),
    .clause_rd_idx  (clause_rd_idx),
    .clause_lits    (clause_lits),
    .vs_rd_en       (vs_rd_en),
    .vs_rd_var      (vs_rd_var),
    .vs_val         (vs_val),
    .vs_unassign    (vs_unassign),
    .imply_full     (imply_full),
    .push_imply     (push_imply),
    .var_in_imply   (var_in_imply),
    .val_in_imply   (val_in_imply),
    .type_in_imply  (type_in_imply),
    .bcp_busy       (bcp_busy),
    .conflict       (conflict),
    .overflow       (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [LITS*LW-1:0] db [16];
  logic               vs_asg [256];
  logic               vs_value [256];

  // Clause DB and var-state memories answer one cycle after their read strobe.
  always @(posedge clock) begin
    if (clause_rd_en) clause_lits <= db[clause_rd_idx[3:0]];
    if (vs_rd_en) begin
      vs_val      <= vs_value[vs_rd_var];
      vs_unassign <= !vs_asg[vs_rd_var];
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int n_rd, n_vs, n_push, n_busy, push_cyc;
  logic [VB-1:0] pvar [4];
  logic          pval [4];

  function automatic logic [LW-1:0] lit(input int v, input logic neg);
    return {1'b1, neg, VB'(v)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_begin;
    @(posedge clock);
    #1;
  endtask

  // Sample at the falling edge and accumulate activity counters.
  task automatic cyc_end;
    @(negedge clock);
    n_rd   += int'(clause_rd_en);
    n_vs   += int'(vs_rd_en);
    n_busy += int'(bcp_busy);
    if (push_imply) begin
      if (n_push < 4) begin
        pvar[n_push] = var_in_imply;
        pval[n_push] = val_in_imply;
      end
      n_push++;
    end
  endtask

  task automatic idle_cyc;
    cyc_begin;
    cyc_end;
  endtask

  task automatic clr_mon;
    n_rd = 0; n_vs = 0; n_push = 0; n_busy = 0; push_cyc = -1;
  endtask

  task automatic pulse_reset_bcp;
    cyc_begin; reset_bcp = 1'b1; cyc_end;
    cyc_begin; reset_bcp = 1'b0; cyc_end;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; reset_bcp = 1'b0; bcp_en = 1'b0; bcp_clause_idx = '0; imply_full = 1'b0;
    clause_lits = '0; vs_val = 1'b0; vs_unassign = 1'b0;
    for (int i = 0; i < 256; i++) begin vs_asg[i] = 1'b0; vs_value[i] = 1'b0; end
    for (int i = 0; i < 16; i++) db[i] = '0;
    vs_asg[1] = 1'b1; vs_value[1] = 1'b0;   // x1 = 0
    vs_asg[2] = 1'b1; vs_value[2] = 1'b1;   // x2 = 1; x3, x6 unassigned
    db[1] = {lit(3, 1'b0), lit(2, 1'b1), lit(1, 1'b0)};   // x1 | ~x2 | x3
    db[2] = {lit(1, 1'b0), lit(1, 1'b0), lit(2, 1'b0)};   // x2 first: satisfied
    db[3] = {{LW{1'b0}}, lit(6, 1'b1), lit(1, 1'b0)};     // x1 | ~x6 : implies x6=0
    db[4] = {lit(2, 1'b1), lit(6, 1'b0), lit(3, 1'b0)};   // two unassigned
    db[5] = {lit(1, 1'b0), lit(3, 1'b0), lit(2, 1'b0)};   // slot 0 satisfied
    db[6] = '0;                                           // empty clause

    // Reset state
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_conflict", conflict, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_push", push_imply, 0);
    chk("rst_rd_en", clause_rd_en, 0);
    chk("rst_vs_rd_en", vs_rd_en, 0);
    chk("rst_busy", bcp_busy, 0);
    chk("rst_buses", {clause_rd_idx, vs_rd_var, val_in_imply, type_in_imply}, 0);
    chk("rst_imply_var", var_in_imply, 0);
    @(negedge clock);
    reset = 1'b1;

    // Unit implication: push at N+7 with var 3, val 1
    clr_mon;
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 1; cyc_end;
    chk("t1_busy_n", bcp_busy, 1);
    cyc_begin; bcp_en = 1'b0; cyc_end;
    chk("t1_rd_en_n1", clause_rd_en, 1);
    chk("t1_rd_idx_n1", clause_rd_idx, 1);
    idle_cyc;
    idle_cyc;
    chk("t1_vs_rd_en_n3", vs_rd_en, 1);
    chk("t1_vs_var_n3", vs_rd_var, 1);
    idle_cyc; idle_cyc; idle_cyc;
    chk("t1_push_n6", push_imply, 0);
    idle_cyc;
    chk("t1_push_n7", push_imply, 1);
    chk("t1_var_n7", var_in_imply, 3);
    chk("t1_val_n7", val_in_imply, 1);
    chk("t1_type_n7", type_in_imply, 1);
    chk("t1_conflict_n7", conflict, 0);
    idle_cyc;
    chk("t1_busy_n8", bcp_busy, 0);
    chk("t1_push_count", n_push, 1);
    chk("t1_vs_reads", n_vs, 3);

    // Conflict: x3 = 0 falsifies every literal
    vs_asg[3] = 1'b1; vs_value[3] = 1'b0;
    clr_mon;
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 1; cyc_end;
    cyc_begin; bcp_en = 1'b0; cyc_end;
    repeat (5) idle_cyc;
    chk("t2_conflict_n6", conflict, 0);
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 2; cyc_end;
    chk("t2_conflict_n7", conflict, 1);
    chk("t2_push_n7", push_imply, 0);
    cyc_begin; bcp_en = 1'b0; cyc_end;
    chk("t2_busy_n8", bcp_busy, 0);
    repeat (3) idle_cyc;
    chk("t2_ignored_intake", n_rd, 1);
    chk("t2_conflict_sticky", conflict, 1);
    pulse_reset_bcp;
    chk("t2_conflict_cleared", conflict, 0);
    vs_asg[3] = 1'b0;

    // Empty clause is a conflict
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 6; cyc_end;
    cyc_begin; bcp_en = 1'b0; cyc_end;
    repeat (6) idle_cyc;
    chk("t2b_empty_clause", conflict, 1);
    pulse_reset_bcp;
    chk("t2b_cleared", conflict, 0);

    // Stream of four clauses on consecutive cycles
    clr_mon;
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 2; cyc_end;
    cyc_begin; bcp_clause_idx = 1; cyc_end;
    cyc_begin; bcp_clause_idx = 3; cyc_end;
    cyc_begin; bcp_clause_idx = 4; cyc_end;
    for (int i = 0; i < 60; i++) begin
      cyc_begin; bcp_en = 1'b0; cyc_end;
      if (!bcp_busy) break;
    end
`ifdef BCP_EARLY_EXIT_EN
    chk("t3_busy_cycles", n_busy, 26);
`else
    chk("t3_busy_cycles", n_busy, 29);
`endif
    chk("t3_push_count", n_push, 2);
    chk("t3_push0", {pvar[0], pval[0]}, {8'd3, 1'b1});
    chk("t3_push1", {pvar[1], pval[1]}, {8'd6, 1'b0});
    chk("t3_overflow", overflow, 0);
    chk("t3_conflict", conflict, 0);

    // Backpressure: imply_full high N+7..N+11, push lands at N+12
    clr_mon;
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 1; cyc_end;
    for (int c = 1; c <= 14; c++) begin
      cyc_begin; bcp_en = 1'b0; imply_full = (c >= 7 && c <= 11); cyc_end;
      if (push_imply && push_cyc < 0) push_cyc = c;
    end
    imply_full = 1'b0;
    chk("t4_push_count", n_push, 1);
    chk("t4_push_cycle", push_cyc, 12);
    chk("t4_push_var", pvar[0], 3);
    chk("t4_busy_cycles", n_busy, 13);

    // Overflow: nine intakes while stalled in OUTCOME, one is dropped
    clr_mon;
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 1; imply_full = 1'b1; cyc_end;
    repeat (9) begin cyc_begin; bcp_en = 1'b0; cyc_end; end
    chk("t5_stalled_no_push", n_push, 0);
    for (int i = 0; i < 9; i++) begin
      cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 2; cyc_end;
      if (i == 8) chk("t5_ovf_before_9th", overflow, 0);
    end
    cyc_begin; bcp_en = 1'b0; cyc_end;
    chk("t5_ovf_set", overflow, 1);
    cyc_begin; imply_full = 1'b0; cyc_end;
    for (int i = 0; i < 100; i++) begin
      idle_cyc;
      if (!bcp_busy) break;
    end
    chk("t5_fetches", n_rd, 9);
    chk("t5_push_count", n_push, 1);
    chk("t5_ovf_sticky", overflow, 1);
    pulse_reset_bcp;
    chk("t5_ovf_cleared", overflow, 0);

    // Asynchronous reset in the middle of SCAN
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 1; cyc_end;
    cyc_begin; bcp_en = 1'b0; cyc_end;
    idle_cyc; idle_cyc; idle_cyc;
    chk("t6_in_scan", vs_rd_en, 1);
    #1 reset = 1'b0;
    #1;
    chk("t6_vs_rd_en", vs_rd_en, 0);
    chk("t6_busy", bcp_busy, 0);
    chk("t6_others", {clause_rd_en, push_imply, conflict, overflow, vs_rd_var}, 0);
    #1 reset = 1'b1;

    // Clause satisfied in slot 0
    clr_mon;
    cyc_begin; bcp_en = 1'b1; bcp_clause_idx = 5; cyc_end;
    for (int i = 0; i < 12; i++) begin
      cyc_begin; bcp_en = 1'b0; cyc_end;
      if (!bcp_busy) break;
    end
`ifdef BCP_EARLY_EXIT_EN
    chk("t7_busy_cycles", n_busy, 5);
    chk("t7_vs_reads", n_vs, 1);
`else
    chk("t7_busy_cycles", n_busy, 8);
    chk("t7_vs_reads", n_vs, 3);
`endif
    chk("t7_push_count", n_push, 0);
    chk("t7_conflict", conflict, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/bcp_clause_eval.md
# bcp_clause_eval

Boolean-constraint-propagation engine sitting directly downstream of the solver control FSM. It accepts the stream of clause indices that control issues during BCP_CORE and fetches each clause from the clause database. Each literal is evaluated against the variable state table, and the engine either pushes a unit implication into the imply queue or raises a sticky conflict. It drives the `bcp_busy` and `conflict` signals that control samples in BCP_WAIT.

## Interface
- `LITS`, default 3: literal slots per clause.
- `FIFO_DEPTH`, default 8: clause-index buffer entries, power of two.
- Widths `MAX_VARS_BITS` and `MAX_CLAUSES_BITS` come from `sysdefs.svh`. Literal width LW = `MAX_VARS_BITS`+2, encoded as {valid, neg, var}.
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `reset_bcp` in 1: synchronous clear of conflict/overflow, FIFO and FSM, active high.
- `bcp_en` in 1: clause index valid this cycle.
- `bcp_clause_idx` in `MAX_CLAUSES_BITS`: clause to evaluate.
- `clause_rd_en` out 1: clause DB read strobe.
- `clause_rd_idx` out `MAX_CLAUSES_BITS`: clause DB address.
- `clause_lits` in LITS*LW: clause literals, valid the cycle after `clause_rd_en`; slot 0 is in the LSBs.
- `vs_rd_en` out 1: var-state read strobe.
- `vs_rd_var` out `MAX_VARS_BITS`: variable to read.
- `vs_val`, `vs_unassign` in 1 each: var-state data, valid the cycle after `vs_rd_en`.
- `imply_full` in 1: imply queue cannot accept.
- `push_imply` out 1: push one implication.
- `var_in_imply` out `MAX_VARS_BITS`: implied variable.
- `val_in_imply` out 1: implied value.
- `type_in_imply` out 1: constant 1 (implied).
- `bcp_busy` out 1: engine has or is receiving work.
- `conflict` out 1: sticky conflict flag.
- `overflow` out 1: sticky flag; an index was dropped because the FIFO was full.

## Operation
- **Intake.**
  - `bcp_en` writes `bcp_clause_idx` into the FIFO.
  - If the FIFO is full, the write is dropped and `overflow` is set.
  - Intake is ignored while `conflict`=1.
- **FSM states:** IDLE, FETCH, LOAD, SCAN, RESOLVE, OUTCOME.
- **IDLE.** Moves to FETCH when the FIFO is non-empty and `conflict`=0.
- **FETCH.** Pops the FIFO and drives `clause_rd_en`=1 with `clause_rd_idx`=head. Then goes to LOAD.
- **LOAD.**
  - Latches `clause_lits`.
  - Clears unassigned count `ucnt` (2 bits, saturating at 2), satisfied flag `sat` and candidate literal `cand`.
  - Then goes to SCAN with k=0.
- **SCAN, k = 0..LITS-1.**
  - Each cycle drives `vs_rd_en`=1 and `vs_rd_var`=var of literal k.
  - Each cycle with k>0 also evaluates the returned data for literal k-1.
  - After k=LITS-1 it goes to RESOLVE.
- **RESOLVE.** Evaluates the last literal, then goes to OUTCOME.
- **Literal evaluation.**
  - valid=0: ignored.
  - `vs_unassign`=1: `ucnt`++ and `cand` = literal.
  - `vs_val` XOR neg = 1: `sat`=1.
  - Otherwise the literal is false.
- **OUTCOME.** Checked in this order:
  - `sat`=1: no action.
  - `ucnt`==0: `conflict` is set, the FIFO is flushed and the FSM goes to IDLE.
  - `ucnt`==1: holds in OUTCOME while `imply_full`=1. Otherwise asserts `push_imply` for one cycle with var=`cand`.var, val=~`cand`.neg, type=1.
  - `ucnt`>=2: no action.
  - Then goes to FETCH if the FIFO is non-empty, else IDLE.
- **Clause with all slots invalid.** Evaluates to a conflict (empty clause).
- **Duplicate implications.** The same variable may be implied twice; this is legal, and control dedups through the var-state table.
- **`bcp_busy`.** Combinational: `bcp_en` | FIFO non-empty | state≠IDLE. A conflict therefore drops `bcp_busy` once IDLE is reached.
- **`reset_bcp`.** Takes precedence over every other action in its cycle. It clears the FIFO, `conflict` and `overflow`, and returns the FSM to IDLE. An intake in the same cycle is dropped.

## Timing
- **Async reset (`reset`=0).** FSM=IDLE, FIFO empty. All outputs 0: `conflict`, `overflow`, `push_imply`, `clause_rd_en`, `vs_rd_en`, `bcp_busy`, and every bus.
- **Start latency.** With `bcp_en` in cycle N into an empty, idle engine: FETCH in N+1, LOAD N+2, SCAN N+3..N+2+LITS, RESOLVE N+3+LITS, OUTCOME N+4+LITS.
  - For LITS=3, `push_imply` or `conflict` appears in cycle N+7.
- **Per-clause cost.** LITS+4 cycles, plus stall cycles for `imply_full`.
  - Back-to-back clauses go OUTCOME→FETCH with no IDLE bubble.
- **`conflict` timing.** Rises at the OUTCOME edge and holds until `reset_bcp` or `reset`.
- **Simultaneous intake and pop.** A simultaneous `bcp_en` and FETCH pop on a full FIFO is accepted, with no overflow.
- **FIFO pointers.** log2(`FIFO_DEPTH`)+1 bits, wrap modulo 2·`FIFO_DEPTH`; full when the MSBs differ and the rest are equal.

## Configuration
- **`BCP_EARLY_EXIT_EN` defined.**
  - In SCAN or RESOLVE, evaluating a satisfied literal ends the clause immediately.
  - Next cycle: FETCH if the FIFO is non-empty, else IDLE.
  - Remaining `vs_rd_en` reads are suppressed.
  - Minimum clause cost: 4 cycles (FETCH, LOAD, SCAN k=0, SCAN k=1).
- **Undefined.** Every clause takes the full LITS+4 cycles; results are identical.

## Test plan
- **Unit implication.** Clause (x1 ∨ ¬x2 ∨ x3) with x1=0, x2=1, x3 unassigned; single `bcp_en` at N → `push_imply` at N+7 with var=3, val=1, type=1; `conflict` stays 0.
- **Conflict.** Same clause with x3=0 → `conflict`=1 at N+7; a later `bcp_en` is ignored; `bcp_busy` falls the cycle after OUTCOME; `reset_bcp` clears `conflict`.
- **Stream.** 4 clauses on consecutive cycles: 1 satisfied, 2 unit, 1 with 2 unassigned → exactly 2 pushes, ~28 cycles total, `overflow`=0.
- **Backpressure.** `imply_full`=1 for 5 cycles during a unit result → FSM holds in OUTCOME; one `push_imply` on the first cycle after `imply_full` drops; no push is lost.
- **Overflow and reset.**
  - 9 back-to-back `bcp_en` with `FIFO_DEPTH`=8 and the engine in a long scan → `overflow`=1 and exactly one index dropped.
  - Asserting `reset` mid-SCAN → all outputs 0 immediately.
- **Early exit.** Clause whose slot 0 is satisfied, with `BCP_EARLY_EXIT_EN` on → clause finishes after 4 cycles with a single `vs_rd_en` pulse.
